// File: rtl/scan_chain_checker.sv
// scan_chain_checker: flushes NUM_CHAINS scan chains, pushes a known pattern
// into every chain head and checks WINDOW samples at each chain tail.
// A mismatch on chain i sets fail_mask[i]. err_count counts all mismatched
// samples and saturates at 16'hFFFF.
// Optional feature macro: SCAN_CHAIN_CHECKER_PRBS_EN. When defined, i_mode=1
// selects a 16-bit PRBS pattern. When undefined, every run uses the
// single-pulse pattern.
module scan_chain_checker #(
    parameter int          NUM_CHAINS = 1,
    parameter int          CHAIN_LEN  = 1024,
    parameter int          TAIL_DELAY = 0,
    parameter int          WINDOW     = 3,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  i_clock,
    input  logic                  i_resetb,
    input  logic                  i_start,
    input  logic                  i_mode,
    output logic [NUM_CHAINS-1:0] o_sc_head,
    input  logic [NUM_CHAINS-1:0] i_sc_tail,
    output logic                  o_scan_en,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_pass,
    output logic [NUM_CHAINS-1:0] o_fail_mask,
    output logic [15:0]           o_err_count
);

    // Edges from a head update to the edge that samples that bit at the tail.
    localparam int LAT   = CHAIN_LEN + TAIL_DELAY + 1;
    localparam int CNT_W = $clog2(LAT + WINDOW + 1);
    localparam int PC_W  = $clog2(NUM_CHAINS + 1);

    localparam logic [CNT_W-1:0] CNT_FLUSH_END = CNT_W'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_CHK_START = CNT_W'(LAT);
    localparam logic [CNT_W-1:0] CNT_PAT_END   = CNT_W'(LAT + WINDOW - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FLUSH   = 2'd1;
    localparam logic [1:0] S_PATTERN = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_head;
    logic                  r_scan_en;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_pass;
    logic [NUM_CHAINS-1:0] r_fail_mask;
    logic [15:0]           r_err_count;

    logic                  w_start_acc;
    logic                  w_check;
    logic                  w_head_next;
    logic                  w_expect;
    logic [NUM_CHAINS-1:0] w_mis;
    logic [PC_W-1:0]       w_popcnt;
    logic [16:0]           w_err_sum;
    logic [15:0]           w_err_next;
    logic [NUM_CHAINS-1:0] w_fail_next;

    assign w_start_acc = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_check     = (r_state == S_PATTERN) && (r_cnt >= CNT_CHK_START);

`ifdef SCAN_CHAIN_CHECKER_PRBS_EN
    logic        r_mode;
    logic [15:0] r_gen_lfsr;
    logic [15:0] r_chk_lfsr;

    // x^16+x^14+x^13+x^11+1 Fibonacci step, shifting toward the LSB.
    function automatic logic [15:0] prbs_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Generator LFSR runs for every PATTERN cycle. The checker LFSR runs only
    // inside the check window, so it trails the generator by LAT.
    always_ff @(posedge i_clock or negedge i_resetb) begin
        if (!i_resetb) begin
            r_mode     <= 1'b0;
            r_gen_lfsr <= LFSR_SEED;
            r_chk_lfsr <= LFSR_SEED;
        end else if (w_start_acc) begin
            r_mode     <= i_mode;
            r_gen_lfsr <= LFSR_SEED;
            r_chk_lfsr <= LFSR_SEED;
        end else if ((r_state == S_PATTERN) && r_mode) begin
            r_gen_lfsr <= prbs_step(r_gen_lfsr);
            if (w_check) begin
                r_chk_lfsr <= prbs_step(r_chk_lfsr);
            end
        end
    end

    assign w_head_next = r_mode ? r_gen_lfsr[0] : (r_cnt == '0);
    assign w_expect    = r_mode ? r_chk_lfsr[0] : (r_cnt == CNT_CHK_START);
`else
    // Only the pulse pattern exists in this build, so mode has no effect.
    logic w_unused_mode;
    assign w_unused_mode = i_mode;
    assign w_head_next   = (r_cnt == '0);
    assign w_expect      = (r_cnt == CNT_CHK_START);
`endif

    // Per-chain compare. An X or Z on a tail counts as a mismatch in simulation.
    for (genvar gi = 0; gi < NUM_CHAINS; gi++) begin : g_cmp
        assign w_mis[gi] = w_check && (i_sc_tail[gi] !== w_expect);
    end

    // Count the mismatches seen this cycle.
    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            w_popcnt = w_popcnt + PC_W'(w_mis[i]);
        end
    end

    assign w_err_sum   = {1'b0, r_err_count} + 17'(w_popcnt);
    assign w_err_next  = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    assign w_fail_next = r_fail_mask | w_mis;

    // Run controller: IDLE/DONE -> FLUSH (LAT cycles) -> PATTERN -> DONE.
    always_ff @(posedge i_clock or negedge i_resetb) begin
        if (!i_resetb) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_head      <= 1'b0;
            r_scan_en   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        r_state     <= S_FLUSH;
                        r_cnt       <= '0;
                        r_head      <= 1'b0;
                        r_scan_en   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail_mask <= '0;
                        r_err_count <= '0;
                    end
                end
                S_FLUSH: begin
                    r_head <= 1'b0;
                    if (r_cnt == CNT_FLUSH_END) begin
                        r_state <= S_PATTERN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_PATTERN: begin
                    r_head <= w_head_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_check) begin
                        r_fail_mask <= w_fail_next;
                        r_err_count <= w_err_next;
                    end
                    if (r_cnt == CNT_PAT_END) begin
                        r_state   <= S_DONE;
                        r_head    <= 1'b0;
                        r_scan_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_pass    <= (w_fail_next == '0);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_sc_head   = {NUM_CHAINS{r_head}};
    assign o_scan_en   = r_scan_en;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_fail_mask = r_fail_mask;
    assign o_err_count = r_err_count;

endmodule

// File: doc/scan_chain_checker.md
Name: scan_chain_checker

Overview:
Synthesizable, parametrised scan-chain self-checker for the FPGA fabric.
- Flushes NUM_CHAINS scan chains, injects a known pattern at each sc_head, and compares every sc_tail against the expected delayed stream over a check window.
- Reports pass/fail per chain.
- Sits in the user project area between the fabric scan ports and the logic analyzer / GPIO, so scan integrity can be tested on silicon without an external bench.

Parameters:
- NUM_CHAINS, 1: number of independent scan chains driven and checked in parallel.
- CHAIN_LEN, 1024: flip-flops per chain (>=1).
- TAIL_DELAY, 0: extra register stages between the chain's last flip-flop and sc_tail (pad/sync pipeline).
- WINDOW, 3: number of tail samples checked per run (>=1).
- LFSR_SEED, 16'hACE1: nonzero seed of the 16-bit PRBS (x^16+x^14+x^13+x^11+1, Fibonacci, shift toward LSB, output = bit 0).

Ports:
- clock  in  1  sole clock; also clocks the scan chains.
- resetb  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a run when not busy.
- mode  in  1  0 = single-pulse pattern, 1 = PRBS pattern; sampled on accepted start.
- sc_head  out  NUM_CHAINS  registered scan-in bit per chain (identical pattern on all chains).
- sc_tail  in  NUM_CHAINS  scan-out bit per chain.
- scan_en  out  1  high during FLUSH and PATTERN; gates chain shifting.
- busy  out  1  high from the cycle after accepted start until DONE is entered.
- done  out  1  high in DONE; held until next accepted start or reset.
- pass  out  1  valid when done; 1 iff fail_mask == 0.
- fail_mask  out  NUM_CHAINS  bit i set on any mismatch on chain i during the current run.
- err_count  out  16  total mismatches over all chains; saturates at 16'hFFFF.

Behaviour:
- Reset values: sc_head=0, scan_en=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, state=IDLE, both LFSRs=LFSR_SEED, counter=0.
- LAT = CHAIN_LEN + TAIL_DELAY + 1: edges from sc_head update to the checker sampling that bit at sc_tail.
- Counter width = $clog2(LAT + WINDOW + 1).
- States:
  - IDLE: waits for start. Accepted start latches mode, clears fail_mask/err_count/done/pass, resets the counter, goes to FLUSH.
  - FLUSH: sc_head=0, scan_en=1 for exactly LAT cycles, then PATTERN with counter t=0.
  - PATTERN: scan_en=1; t increments every cycle.
    - Drive: pulse mode drives sc_head=1 only at t=0, else 0. PRBS mode drives the generator LFSR output and advances it every cycle.
    - Check: when LAT <= t < LAT+WINDOW, each sc_tail[i] is compared with expected(t) = pattern(t-LAT). In PRBS mode, expected comes from a second LFSR seeded identically and advanced from t=LAT onward.
    - Mismatch on chain i sets fail_mask[i]. err_count adds the popcount of mismatches that cycle, saturating.
    - At t = LAT+WINDOW-1 (last sample), go to DONE.
  - DONE: scan_en=0, sc_head=0, done=1, pass=(fail_mask==0). An accepted start restarts as in IDLE.
- Run length: start accepted at edge n gives done=1 after edge n + 2*LAT + WINDOW.
- start while busy is ignored. start and reset together: reset wins.
- mode changes after start have no effect until the next run.
- resetb asserted mid-run aborts immediately to reset values. Chains are not flushed until the next start.
- X/Z on sc_tail counts as a mismatch (compare with case inequality semantics in simulation; synthesised logic treats the value as read).

Optional Feature:
SCAN_CHAIN_CHECKER_PRBS_EN.
- Defined: both LFSRs are built and mode selects the pattern.
- Undefined: no LFSRs, mode is ignored, and every run uses the single-pulse pattern. Area shrinks accordingly.

Test Plan:
- Pulse, NUM_CHAINS=1, CHAIN_LEN=8, TAIL_DELAY=0, WINDOW=3, ideal 8-FF chain model: start -> samples 1,0,0; done after 2*9+3=21 edges; pass=1, err_count=0, fail_mask=0.
- Same setup, chain model with one stuck-at-0 FF: pulse run -> fail_mask=1, err_count=1, pass=0.
- PRBS (macro defined), NUM_CHAINS=2, CHAIN_LEN=16, TAIL_DELAY=1, WINDOW=32; chain 1 has a bit flip injected at sample 5 -> fail_mask=2'b10, err_count=1; chain 0 clean.
- Reset mid-PATTERN: resetb low for 1 cycle at t=4 -> all outputs 0 and state IDLE; fresh start -> correct pass result.
- start pulsed during FLUSH, and mode toggled mid-run -> ignored; run completes with the original mode at the original cycle count.
- Saturation: WINDOW=70000, chain tail tied to 1 in pulse mode -> err_count stops at 16'hFFFF, pass=0.
